// File: rtl/lfsr_checker.sv
// Receive-side checker for a Galois LFSR word stream: hunts for a seed, verifies,
// locks, and counts mismatches while locked. Drops lock after a run of bad words.
//
// state  | meaning
// HUNT   | waiting for a non-zero word to seed the expected next state
// VERIFY | seeded; counting consecutive good words toward lock
// LOCKED | in lock; every word counted, mismatches flagged and counted
module lfsr_checker #(
    parameter int              N        = 26,
    parameter logic [N-1:0]    TAPS     = 26'h47,
    parameter int              LOCK_CNT = 4,
    parameter int              LOSS_CNT = 3,
    parameter int              CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [N-1:0]     in_data_i,
    input  logic             resync_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic             zero_err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] word_count_o
);

    localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       expected_q, expected_d;
    logic [RUN_W-1:0]   good_run_q, good_run_d;
    logic [RUN_W-1:0]   bad_run_q, bad_run_d;
    logic               err_pulse_q, err_pulse_d;
    logic               zero_err_q, zero_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;

    logic               is_zero;
    logic               is_match;
    logic [RUN_W-1:0]   good_next;
    logic [RUN_W-1:0]   bad_next;

    function automatic logic [N-1:0] step(input logic [N-1:0] x);
        return {x[N-2:0], 1'b0} ^ (x[N-1] ? TAPS : '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign is_zero   = (in_data_i == '0);
    assign is_match  = (in_data_i == expected_q) && !is_zero;
    assign good_next = good_run_q + RUN_W'(1);
    assign bad_next  = bad_run_q + RUN_W'(1);

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        err_pulse_d  = 1'b0;
        zero_err_d   = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;

        // resync wins over a word presented in the same cycle
        if (resync_i) begin
            state_d    = HUNT;
            good_run_d = '0;
            bad_run_d  = '0;
        end else if (in_valid_i) begin
            zero_err_d = is_zero;
            unique case (state_q)
                HUNT: begin
                    if (!is_zero) begin
                        expected_d = step(in_data_i);
                        good_run_d = '0;
                        state_d    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_zero) begin
                        good_run_d = '0;
                    end else if (is_match) begin
                        expected_d = step(expected_q);
                        if (good_next == RUN_W'(LOCK_CNT)) begin
                            state_d    = LOCKED;
                            good_run_d = '0;
                            bad_run_d  = '0;
                        end else begin
                            good_run_d = good_next;
                        end
                    end else begin
                        expected_d = step(in_data_i);
                        good_run_d = '0;
                    end
                end
                LOCKED: begin
                    word_count_d = sat_inc(word_count_q);
                    expected_d   = step(expected_q);
                    if (is_match) begin
                        bad_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                        if (bad_next == RUN_W'(LOSS_CNT)) begin
                            state_d    = HUNT;
                            bad_run_d  = '0;
                            good_run_d = '0;
                        end else begin
                            bad_run_d = bad_next;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HUNT;
            expected_q   <= '0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            err_pulse_q  <= 1'b0;
            zero_err_q   <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            err_pulse_q  <= err_pulse_d;
            zero_err_q   <= zero_err_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign err_pulse_o  = err_pulse_q;
    assign zero_err_o   = zero_err_q;
    assign err_count_o  = err_count_q;
    assign word_count_o = word_count_q;

endmodule
